// File: rtl/jk_sync_counter_pkg.sv
// Shared definitions for the JK-cell based synchronous counter:
// JK mode encodings and the modulus legality check.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_mode_e;

  // Legal modulus range is 2 .. 2**width.
  function automatic bit modulus_ok(int width, int modulus);
    return (width >= 1) && (width < 31) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of the modulo-N JK counter; the counter is the slave,
// whoever drives en/load is the master.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/jk_toggle_cell.sv
// Posedge JK flip-flop with asynchronous active-low reset clearing Q.
module jk_toggle_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD:   Q <= Q;
        JK_RESET:  Q <= 1'b0;
        JK_SET:    Q <= 1'b1;
        JK_TOGGLE: Q <= ~Q;
        default:   Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter: one JK toggle cell per bit, shared next-state
// logic drives J=K=count^next, plus combinational tc and registered pulses.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  jk_sync_counter_if.slave   bus
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("jk_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] LAST_EXT = MOD_EXT - ONE_EXT;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] jk_drive;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;
  logic             at_last;
  logic             at_zero;
  logic             load_ok;
  logic             wrap_d;
  logic             load_err_d;
  logic             wrap_p1;
  logic             load_err_p1;
  logic             unused_next_msb;

  // Wrap is found by comparing against the end points, so the extra bit never carries.
  assign count_ext = {1'b0, count_q};
  assign load_ext  = {1'b0, bus.load_val};
  assign at_last   = (count_ext == LAST_EXT);
  assign at_zero   = (count_ext == '0);
  assign load_ok   = (load_ext < MOD_EXT);

  always_comb begin
    next_ext   = count_ext;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        next_ext = load_ext;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_last) begin
          next_ext = '0;
          wrap_d   = 1'b1;
        end else begin
          next_ext = count_ext + ONE_EXT;
        end
      end else begin
        if (at_zero) begin
          next_ext = LAST_EXT;
          wrap_d   = 1'b1;
        end else begin
          next_ext = count_ext - ONE_EXT;
        end
      end
    end
  end

  assign unused_next_msb = next_ext[WIDTH];

  // Toggle exactly the bits that differ; a bit that must stay gets J=K=0.
  assign jk_drive = count_q ^ next_ext[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_toggle_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .J     (jk_drive[i]),
      .K     (jk_drive[i]),
      .Q     (count_q[i])
    );
  end

  // Stage p1: one-cycle status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_p1     <= 1'b0;
      load_err_p1 <= 1'b0;
    end else begin
      wrap_p1     <= wrap_d;
      load_err_p1 <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = bus.en & ~bus.load & (bus.up_dn ? at_last : at_zero);
  assign bus.wrap     = wrap_p1;
  assign bus.load_err = load_err_p1;

endmodule
